mem_unit: RTL and testbench
===========================

MEM_UNIT -- requirements
Module: mem_unit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 24, word width of both memories.
REQ-002 SHALL have parameter IADDR_W, default 15, instruction address width; instruction depth = 2**IADDR_W.
REQ-003 SHALL have parameter DADDR_W, default 14, data address width.
REQ-004 SHALL have parameter DATA_DEPTH, default 16384, populated data words; must be <= 2**DADDR_W.
REQ-005 SHALL have parameter CLEAR_ON_RESET, default 1; 1 = zero-fill data memory after reset.
REQ-006 SHALL have one clock and asynchronous active-low reset: mem_clk in 1, rising-edge clock; mem_rst_n in 1, async reset, active low.
REQ-007 SHALL have pc in IADDR_W, instruction fetch address.
REQ-008 SHALL have instr_out out DATA_WIDTH, registered fetched word.
REQ-009 SHALL have prog_we in 1 (instruction write strobe), prog_addr in IADDR_W, and prog_data in DATA_WIDTH.
REQ-010 SHALL have d_req in 1 (data request), d_we in 1 (1 = store, 0 = load), d_addr in DADDR_W and d_wdata in DATA_WIDTH.
REQ-011 SHALL have d_ack out 1 (one-cycle completion pulse), d_rdata out DATA_WIDTH (load data) and d_err out 1 (out-of-range, valid with d_ack).
REQ-012 SHALL have ready out 1, high when the data port accepts requests.

Function
REQ-013 SHALL implement FSM states CLEAR, IDLE and ACCESS.
REQ-014 CLEAR SHALL write zero to data address clr_cnt on each cycle, clr_cnt running 0..DATA_DEPTH-1, then go to IDLE; it lasts exactly DATA_DEPTH cycles.
REQ-015 In IDLE, if d_req=1 it SHALL latch d_we, d_addr and d_wdata and go to ACCESS; if d_we=1 and d_addr<DATA_DEPTH, the store SHALL commit on that edge.
REQ-016 ACCESS SHALL assert d_ack=1 for exactly one cycle and return to IDLE; d_rdata and d_err SHALL be valid in that cycle.
REQ-017 A load SHALL return data_mem[d_addr] in d_rdata; a store SHALL drive d_rdata=0.
REQ-018 If d_addr >= DATA_DEPTH: no write, d_rdata=0, d_err=1 with d_ack.
REQ-019 The requester SHALL hold d_req and its operands stable until d_ack; d_req still high in the cycle after d_ack SHALL start a new access, so throughput is one access per 2 cycles.
REQ-020 d_req in CLEAR SHALL be ignored, with no ack and no latch; ready=1 only in IDLE.
REQ-021 instr_out SHALL be updated every cycle to instr_mem[pc], with 1-cycle latency, in all states.
REQ-022 prog_we=1 SHALL write prog_data to instr_mem[prog_addr] on that edge, in any state.
REQ-023 If prog_we=1 and prog_addr==pc in the same cycle, instr_out SHALL show prog_data the next cycle (write-first bypass).
REQ-024 Instruction memory SHALL NOT be cleared by reset.
REQ-025 A load following a store to the same address SHALL return the stored value.
REQ-026 With CLEAR_ON_RESET=0, reset SHALL go directly to IDLE, and data contents SHALL be retained.

Reset
REQ-027 While mem_rst_n=0: state=CLEAR (or IDLE if CLEAR_ON_RESET=0), clr_cnt=0, instr_out=0, d_ack=0, d_rdata=0, d_err=0, ready=0.
REQ-028 Reset asserted mid-CLEAR SHALL restart the clear from address 0.
REQ-029 Reset asserted in ACCESS SHALL drop d_ack immediately; a store committed on the prior edge SHALL remain.

Structure
REQ-030 A shared package mem_pkg SHALL hold the FSM state enum and the default width/depth constants.
REQ-031 One sub-module, mem_sp_ram (parametrised single-port synchronous RAM, write-first), SHALL be instantiated twice, for instruction and data memory.

Verification
REQ-032 Reset release, DATA_DEPTH=16 -> ready=0 for 16 cycles, then ready=1; load any address 0..15 -> d_rdata=0, d_err=0.
REQ-033 Store 0x000003 at addr 1, then load addr 1 -> d_ack one cycle each; load returns 0x000003 with d_err=0.
REQ-034 Load addr 20 with DATA_DEPTH=16 -> d_ack=1, d_err=1, d_rdata=0; subsequent load of addr 4 (wrapped index) unchanged.
REQ-035 prog_we with prog_addr=5, prog_data=0xA0_0011 while pc=5 -> next cycle instr_out=0xA00011.
REQ-036 d_req held high for 6 cycles -> exactly 3 d_ack pulses on alternate cycles.
REQ-037 mem_rst_n pulsed low at clear cycle 7 -> clear restarts; ready rises exactly DATA_DEPTH cycles after release.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared FSM state encoding and default geometry for the memory unit.
// Pure declarations: no latency, no flow control.
package mem_pkg;
   localparam int DATA_WIDTH_DEF = 24;
   localparam int IADDR_W_DEF    = 15;
   localparam int DADDR_W_DEF    = 14;
   localparam int DATA_DEPTH_DEF = 16384;

   typedef enum logic [1:0] {
      ST_CLEAR  = 2'd0,
      ST_IDLE   = 2'd1,
      ST_ACCESS = 2'd2
   } mem_state_t;
endpackage

// File: rtl/mem_sp_ram.sv
// Synchronous RAM, one write and one read address, write-first on a same-address collision.
// Read data registered (1 cycle), reset to zero; always accepts, no backpressure.
module mem_sp_ram
   import mem_pkg::*;
#(
   parameter int DW = DATA_WIDTH_DEF,
   parameter int AW = DADDR_W_DEF
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);

   logic [DW-1:0] mem [0:(2**AW)-1];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // Array contents are never reset; only the output register is.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata <= '0;
      end else if (we && (waddr == raddr)) begin
         rdata <= wdata;
      end else begin
         rdata <= mem[raddr];
      end
   end

endmodule

// File: rtl/mem_unit.sv
// Instruction fetch memory plus request/ack data memory with optional zero-fill after reset.
// Fetch: 1 cycle; data: ack 1 cycle after accept, 2 cycles per access; requests ignored (ready=0) outside IDLE.
module mem_unit
   import mem_pkg::*;
#(
   parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
   parameter int IADDR_W        = IADDR_W_DEF,
   parameter int DADDR_W        = DADDR_W_DEF,
   parameter int DATA_DEPTH     = DATA_DEPTH_DEF,
   parameter int CLEAR_ON_RESET = 1
) (
   input  logic                  mem_clk,
   input  logic                  mem_rst_n,
   input  logic [IADDR_W-1:0]    pc,
   output logic [DATA_WIDTH-1:0] instr_out,
   input  logic                  prog_we,
   input  logic [IADDR_W-1:0]    prog_addr,
   input  logic [DATA_WIDTH-1:0] prog_data,
   input  logic                  d_req,
   input  logic                  d_we,
   input  logic [DADDR_W-1:0]    d_addr,
   input  logic [DATA_WIDTH-1:0] d_wdata,
   output logic                  d_ack,
   output logic [DATA_WIDTH-1:0] d_rdata,
   output logic                  d_err,
   output logic                  ready
);

   localparam logic [DADDR_W:0]   DEPTH_L  = (DADDR_W+1)'(DATA_DEPTH);
   localparam logic [DADDR_W-1:0] CLR_LAST = DADDR_W'(DATA_DEPTH - 1);

   mem_state_t            state, state_nxt;
   logic [DADDR_W-1:0]    clr_cnt, clr_nxt;
   logic                  lat_we, lat_err;
   logic                  start;
   logic                  in_range;
   logic                  dm_we;
   logic [DADDR_W-1:0]    dm_waddr;
   logic [DATA_WIDTH-1:0] dm_wdata;
   logic [DATA_WIDTH-1:0] dm_rdata;

   assign in_range = ({1'b0, d_addr} < DEPTH_L);

   always_ff @(posedge mem_clk or negedge mem_rst_n) begin
      if (!mem_rst_n) begin
         state   <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
         clr_cnt <= '0;
         lat_we  <= 1'b0;
         lat_err <= 1'b0;
      end else begin
         state   <= state_nxt;
         clr_cnt <= clr_nxt;
         if (start) begin
            lat_we  <= d_we;
            lat_err <= ~in_range;
         end
      end
   end

   // Load address/data are captured by the data RAM's read register on the accept edge.
   always_comb begin
      state_nxt = state;
      clr_nxt   = clr_cnt;
      start     = 1'b0;
      dm_we     = 1'b0;
      dm_waddr  = d_addr;
      dm_wdata  = d_wdata;
      d_ack     = 1'b0;
      d_rdata   = '0;
      d_err     = 1'b0;
      ready     = 1'b0;
      case (state)
         ST_CLEAR: begin
            dm_we    = 1'b1;
            dm_waddr = clr_cnt;
            dm_wdata = '0;
            if (clr_cnt == CLR_LAST) begin
               clr_nxt   = '0;
               state_nxt = ST_IDLE;
            end else begin
               clr_nxt = clr_cnt + 1'b1;
            end
         end
         ST_IDLE: begin
            ready = mem_rst_n;
            if (d_req) begin
               start     = 1'b1;
               state_nxt = ST_ACCESS;
               dm_we     = d_we & in_range & mem_rst_n;
            end
         end
         ST_ACCESS: begin
            d_ack     = 1'b1;
            d_err     = lat_err;
            d_rdata   = (lat_we || lat_err) ? '0 : dm_rdata;
            state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   mem_sp_ram #(
      .DW (DATA_WIDTH),
      .AW (IADDR_W)
   ) u_imem (
      .clk   (mem_clk),
      .rst_n (mem_rst_n),
      .we    (prog_we),
      .waddr (prog_addr),
      .wdata (prog_data),
      .raddr (pc),
      .rdata (instr_out)
   );

   mem_sp_ram #(
      .DW (DATA_WIDTH),
      .AW (DADDR_W)
   ) u_dmem (
      .clk   (mem_clk),
      .rst_n (mem_rst_n),
      .we    (dm_we),
      .waddr (dm_waddr),
      .wdata (dm_wdata),
      .raddr (d_addr),
      .rdata (dm_rdata)
   );

endmodule

// File: tb/tb_mem_unit.sv
// Directed bench for mem_unit with a 16-word data memory and a small instruction memory.
module tb_mem_unit;
   localparam int DW    = 24;
   localparam int IAW   = 6;
   localparam int DAW   = 5;
   localparam int DEPTH = 16;

   logic           clk = 1'b0;
   logic           rst_n;
   logic [IAW-1:0] pc;
   logic [DW-1:0]  instr_out;
   logic           prog_we;
   logic [IAW-1:0] prog_addr;
   logic [DW-1:0]  prog_data;
   logic           d_req, d_we;
   logic [DAW-1:0] d_addr;
   logic [DW-1:0]  d_wdata;
   logic           d_ack, d_err, ready;
   logic [DW-1:0]  d_rdata;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mem_unit #(
      .DATA_WIDTH     (DW),
      .IADDR_W        (IAW),
      .DADDR_W        (DAW),
      .DATA_DEPTH     (DEPTH),
      .CLEAR_ON_RESET (1)
   ) dut (
      .mem_clk   (clk),
      .mem_rst_n (rst_n),
      .pc        (pc),
      .instr_out (instr_out),
      .prog_we   (prog_we),
      .prog_addr (prog_addr),
      .prog_data (prog_data),
      .d_req     (d_req),
      .d_we      (d_we),
      .d_addr    (d_addr),
      .d_wdata   (d_wdata),
      .d_ack     (d_ack),
      .d_rdata   (d_rdata),
      .d_err     (d_err),
      .ready     (ready)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // One access from IDLE: expects ack on the first edge and a single-cycle pulse.
   task automatic access(input logic we, input logic [DAW-1:0] addr, input logic [DW-1:0] wdata,
                         output logic [DW-1:0] rdata, output logic err);
      int n;
      @(negedge clk);
      d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
      n = 0;
      do begin
         @(posedge clk); #1; n++;
      end while (!d_ack && n < 20);
      chk("ack_latency", n, 1);
      rdata = d_rdata;
      err   = d_err;
      @(negedge clk);
      d_req = 1'b0; d_we = 1'b0;
      @(posedge clk); #1;
      chk("ack_pulse", d_ack, 0);
   endtask

   // Counts edges from a negedge reset release until ready rises.
   task automatic wait_clear(output int n, output int acks);
      n = 0; acks = 0;
      while (!ready && n < 40) begin
         @(posedge clk); #1;
         n++;
         if (d_ack) acks++;
      end
   endtask

   logic [DW-1:0] rd;
   logic          er;
   logic [5:0]    pat;
   int            n, acks;
   logic [DAW-1:0] zaddr [4] = '{5'd0, 5'd2, 5'd7, 5'd15};

   initial begin
      rst_n = 1'b0; pc = '0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
      d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ready", ready, 0);
      chk("rst_ack", d_ack, 0);
      chk("rst_rdata", d_rdata, 0);
      chk("rst_err", d_err, 0);
      chk("rst_instr", instr_out, 0);

      // Store request held during clear must be ignored.
      @(negedge clk);
      rst_n = 1'b1;
      d_req = 1'b1; d_we = 1'b1; d_addr = 5'd2; d_wdata = 24'h123456;
      wait_clear(n, acks);
      d_req = 1'b0; d_we = 1'b0;
      chk("clear_len", n, DEPTH);
      chk("clear_noack", acks, 0);

      foreach (zaddr[i]) begin
         access(1'b0, zaddr[i], '0, rd, er);
         chk("zero_rdata", rd, 0);
         chk("zero_err", er, 0);
      end

      access(1'b1, 5'd1, 24'h000003, rd, er);
      chk("st1_rdata", rd, 0);
      chk("st1_err", er, 0);
      access(1'b0, 5'd1, '0, rd, er);
      chk("ld1_rdata", rd, 24'h000003);
      chk("ld1_err", er, 0);

      access(1'b1, 5'd4, 24'h00ABCD, rd, er);
      access(1'b1, 5'd20, 24'hFFFFFF, rd, er);
      chk("st20_err", er, 1);
      chk("st20_rdata", rd, 0);
      access(1'b0, 5'd20, '0, rd, er);
      chk("ld20_err", er, 1);
      chk("ld20_rdata", rd, 0);
      access(1'b0, 5'd4, '0, rd, er);
      chk("ld4_rdata", rd, 24'h00ABCD);
      chk("ld4_err", er, 0);

      access(1'b1, 5'd15, 24'h7FFFFF, rd, er);
      access(1'b0, 5'd15, '0, rd, er);
      chk("ld15_rdata", rd, 24'h7FFFFF);
      chk("ld15_err", er, 0);

      // Instruction write-first bypass, then a write elsewhere leaves the fetch untouched.
      @(negedge clk);
      pc = 6'd5; prog_we = 1'b1; prog_addr = 6'd5; prog_data = 24'hA00011;
      @(posedge clk); #1;
      chk("bypass", instr_out, 24'hA00011);
      @(negedge clk);
      prog_addr = 6'd6; prog_data = 24'h123456;
      @(posedge clk); #1;
      chk("fetch_hold", instr_out, 24'hA00011);
      @(negedge clk);
      prog_we = 1'b0; pc = 6'd6;
      @(posedge clk); #1;
      chk("fetch6", instr_out, 24'h123456);

      @(negedge clk);
      d_req = 1'b1; d_we = 1'b0; d_addr = 5'd1;
      pat = '0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         pat = {pat[4:0], d_ack};
         if (d_ack) chk("burst_rdata", d_rdata, 24'h000003);
      end
      @(negedge clk);
      d_req = 1'b0;
      chk("burst_pattern", pat, 6'b101010);

      // Reset while in ACCESS drops the ack immediately.
      @(negedge clk);
      d_req = 1'b1; d_we = 1'b1; d_addr = 5'd9; d_wdata = 24'h0000AA; pc = 6'd5;
      @(posedge clk); #1;
      chk("acc_ack", d_ack, 1);
      rst_n = 1'b0;
      #1;
      chk("rst_acc_ack", d_ack, 0);
      chk("rst_acc_ready", ready, 0);
      d_req = 1'b0; d_we = 1'b0;

      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("fetch_in_clear", instr_out, 24'hA00011);
      repeat (6) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      wait_clear(n, acks);
      chk("reclear_len", n, DEPTH);

      access(1'b0, 5'd1, '0, rd, er);
      chk("cleared1", rd, 0);
      access(1'b0, 5'd4, '0, rd, er);
      chk("cleared4", rd, 0);
      access(1'b0, 5'd9, '0, rd, er);
      chk("cleared9", rd, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
